// File: rtl/arb_pkg.sv
// Shared types and helpers for the weighted round-robin arbiter.
// Holds the FSM state encoding and the one-hot to binary index conversion.
package arb_pkg;

    localparam int ARB_MAX_N = 32;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_e;

    function automatic logic [4:0] onehot_to_bin(input logic [ARB_MAX_N-1:0] oh);
        logic [4:0] b;
        b = '0;
        for (int i = 0; i < ARB_MAX_N; i++) begin
            if (oh[i]) begin
                b = b | 5'(i);
            end
        end
        return b;
    endfunction

endpackage

// File: rtl/rr_mask_pick.sv
// Combinational round-robin winner picker: requesters above ptr take priority,
// otherwise the lowest-index request overall wins. Output is one-hot or zero.
module rr_mask_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  pick
);

    logic [N-1:0] masked;
    logic [N-1:0] pick_m;
    logic [N-1:0] pick_u;
    logic         found_m;
    logic         found_u;

    always_comb begin
        masked  = '0;
        pick_m  = '0;
        pick_u  = '0;
        found_m = 1'b0;
        found_u = 1'b0;
        for (int i = 0; i < N; i++) begin
            masked[i] = req[i] && (IW'(i) > ptr);
        end
        for (int i = 0; i < N; i++) begin
            if (masked[i] && !found_m) begin
                pick_m[i] = 1'b1;
                found_m   = 1'b1;
            end
            if (req[i] && !found_u) begin
                pick_u[i] = 1'b1;
                found_u   = 1'b1;
            end
        end
        pick = found_m ? pick_m : pick_u;
    end

endmodule

// File: rtl/weighted_rr_arbiter.sv
// Weighted round-robin arbiter: the owner keeps its registered one-hot grant
// for up to max(weight,1) acked beats or until it drops req, then priority rotates.
module weighted_rr_arbiter
    import arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int WW = 4,
    parameter int IW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic [N*WW-1:0] weight,
    input  logic            ack,
    output logic [N-1:0]    grant,
    output logic            grant_valid,
    output logic [IW-1:0]   grant_id
);

    arb_state_e    state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [WW-1:0] credit_q, credit_d;
    logic [N-1:0]  grant_q, grant_d;
    logic          grant_valid_q, grant_valid_d;
    logic [IW-1:0] grant_id_q, grant_id_d;

    logic          rel_budget;
    logic          rel_withdraw;
    logic [N-1:0]  pick_req;
    logic [IW-1:0] pick_ptr;
    logic [N-1:0]  pick;
    logic [IW-1:0] pick_id;
    logic [WW-1:0] pick_w;
    logic [WW-1:0] pick_load;

    // On release the pointer moves to the outgoing owner, so the picker sees it now.
    assign rel_budget   = (state_q == OWN) && ack && (credit_q == WW'(1));
    assign rel_withdraw = (state_q == OWN) && ((req & grant_q) == '0);
    assign pick_req     = rel_withdraw ? (req & ~grant_q) : req;
    assign pick_ptr     = (state_q == OWN) ? grant_id_q : ptr_q;
    assign pick_id      = IW'(onehot_to_bin(ARB_MAX_N'(pick)));
    assign pick_w       = weight[pick_id*WW +: WW];
    assign pick_load    = (pick_w == '0) ? WW'(1) : pick_w;

    rr_mask_pick #(.N(N), .IW(IW)) u_pick (
        .req  (pick_req),
        .ptr  (pick_ptr),
        .pick (pick)
    );

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        credit_d      = credit_q;
        grant_d       = grant_q;
        grant_id_d    = grant_id_q;
        unique case (state_q)
            IDLE: begin
                if (pick != '0) begin
                    state_d    = OWN;
                    grant_d    = pick;
                    grant_id_d = pick_id;
                    credit_d   = pick_load;
                end
            end
            OWN: begin
                if (ack) begin
                    credit_d = credit_q - WW'(1);
                end
                if (rel_budget || rel_withdraw) begin
                    ptr_d = grant_id_q;
                    if (pick != '0) begin
                        grant_d    = pick;
                        grant_id_d = pick_id;
                        credit_d   = pick_load;
                    end else begin
                        state_d    = IDLE;
                        grant_d    = '0;
                        grant_id_d = '0;
                        credit_d   = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        grant_valid_d = (grant_d != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            ptr_q         <= IW'(N - 1);
            credit_q      <= '0;
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
            grant_id_q    <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            credit_q      <= credit_d;
            grant_q       <= grant_d;
            grant_valid_q <= grant_valid_d;
            grant_id_q    <= grant_id_d;
        end
    end

    assign grant       = grant_q;
    assign grant_valid = grant_valid_q;
    assign grant_id    = grant_id_q;

endmodule

// File: doc/weighted_rr_arbiter.md
# weighted_rr_arbiter

Parametrised weighted round-robin arbiter for N requesters sharing one downstream resource. Each requester holds its grant for up to a programmable number of accepted beats (its weight) before priority rotates. The grant is registered, one-hot and handshaked with the downstream `ack`. It sits between request sources and a shared bus or port mux, in place of the fixed single-cycle round-robin arbiters where bandwidth shares must be unequal.

## Interface
- `N`, 4, number of requesters; legal range 2..32
- `WW`, 4, width of each weight field, in bits
- `IW`, `$clog2(N)`, width of `grant_id` (derived; do not override)

- `clk` in 1: single clock, rising edge
- `rst` in 1: reset; synchronous, active-high
- `req` in N: request per requester; level-sensitive
- `weight` in N*WW: per-requester weight; field i is `weight[i*WW +: WW]`; quasi-static, sampled when a grant is issued
- `ack` in 1: downstream accepted one beat from the current owner this cycle
- `grant` out N: registered one-hot grant; all-zero when idle
- `grant_valid` out 1: equals `|grant`
- `grant_id` out IW: binary index of the owner; 0 when idle

## Operation
- Two states:
  - `IDLE`: no owner.
  - `OWN`: `grant[k]` held.
- Winner selection (combinational, evaluated in `IDLE` and on release):
  - Mask all requesters at or below pointer `ptr`.
  - The lowest-index masked request wins.
  - If no masked request exists, the lowest-index unmasked request wins.
- On issue to requester k:
  - Load `credit` with `weight[k]`; weight 0 is treated as 1.
  - Go to `OWN`.
- In `OWN`, each `ack` cycle decrements `credit`.
- Release conditions, evaluated every cycle in `OWN`:
  - (a) `ack` with `credit == 1` (budget exhausted)
  - (b) `req[k] == 0` (owner withdrew)
- On release:
  - Set `ptr` to k.
  - Run winner selection on the current `req` with `req[k]` forced to 0 for case (b).
  - If a winner exists, issue to it directly in the same edge; there is no idle cycle.
  - Otherwise go to `IDLE`.
- Case (a) when k is the only requester: k is re-granted with a fresh credit load. It wins through the unmasked path.
- `ack` while `IDLE` is ignored.
- `ack` and `req[k]` low in the same cycle: the beat is counted, then release proceeds under (b).
- `credit` is WW bits wide. Decrement never underflows, because release occurs at `credit == 1`.
- Changing `weight[k]` during ownership by k has no effect until k's next issue.

## Timing
- Reset values:
  - `grant = 0`, `grant_valid = 0`, `grant_id = 0`
  - `ptr = N-1`, so requester 0 has highest priority after reset
  - `credit = 0`, state `IDLE`
- Latency: `req` rises in cycle t while `IDLE` → `grant` high in cycle t+1.
- Handover: the release condition is seen in cycle t → the new `grant` appears in cycle t+1. At most one bit of `grant` is set in every cycle.
- The owner keeps `grant` for exactly W `ack` cycles, where W = max(weight, 1), unless it drops `req` earlier. Cycles without `ack` do not consume credit.
- `rst` asserted mid-ownership: all outputs take reset values at the next edge, and all pending credit is discarded.
- Outputs are pure register outputs, with no combinational path from inputs.

## Structure
- Package `arb_pkg` holds:
  - `ARB_MAX_N = 32`
  - the state enumeration type (`IDLE`, `OWN`)
  - a one-hot-to-binary function, used for `grant_id`
- Sub-module `rr_mask_pick` (purely combinational): inputs `req[N]`, `ptr[IW]`; output one-hot winner `pick[N]`. It contains the masked and unmasked priority chains. The top level holds the state, `ptr`, `credit` and the output registers.

## Test plan
- Reset, N=4, all weights 1, `req=4'b1111`, `ack` held high → `grant` sequence 0001, 0010, 0100, 1000, 0001, one change per cycle, no gaps.
- Weights {1,3,1,2}, `req=1111`, `ack=1` → `grant` sequence 0001 ×1, 0010 ×3, 0100 ×1, 1000 ×2, repeating.
- Weight 2 for requester 1 alone, `ack` pulsed every other cycle → `grant=0010` continuously, re-issued after every 2 acks, `grant_id=1`.
- Owner 2 with credit 3 drops `req[2]` after 1 ack while `req[0]` is high → next cycle `grant=0001`, `ptr=2`.
- Weight 0 on requester 3, only `req[3]` high → `grant=1000` released after 1 ack and immediately re-granted.
- Reset pulse during ownership of requester 1 → next cycle `grant=0`. Then `req=1111` → `grant=0001`.
